// File: rtl/uart_word_tx_if.sv
// Control, memory-read and serial-output signals of the word transmitter.
// The slave side is uart_word_tx; the master side is the controller plus memory.
interface uart_word_tx_if;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_addr;
  logic        tx;
  logic        busy;
  logic        done;
  logic        led_tx;

  modport master (
    output start, start_addr, end_addr, mem_data,
    input  mem_addr, tx, busy, done, led_tx
  );

  modport slave (
    input  start, start_addr, end_addr, mem_data,
    output mem_addr, tx, busy, done, led_tx
  );
endinterface

// File: rtl/uart_word_tx.sv
// Streams memory words start_addr..end_addr (inclusive, 16-bit wrapping) out of tx
// as two 8N1 bytes per word, high byte first, with its own baud counter.
module uart_word_tx #(
  parameter int BAUD_DIV    = 868,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk_100,
  input  logic          rst,
  uart_word_tx_if.slave bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_WAIT      = 4'd2;
  localparam logic [3:0] S_LATCH     = 4'd3;
  localparam logic [3:0] S_START_BIT = 4'd4;
  localparam logic [3:0] S_DATA_BITS = 4'd5;
  localparam logic [3:0] S_STOP_BIT  = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_FINISH    = 4'd8;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [1:0]  WAIT_LAST = 2'(MEM_LATENCY - 1);

  logic [3:0]  state;
  logic [15:0] baud_cnt;
  logic [1:0]  wait_cnt;
  logic [2:0]  bit_cnt;
  logic [15:0] mem_addr_q;
  logic [15:0] end_addr_q;
  logic [7:0]  shifter;
  logic [7:0]  word_lo;
  logic        byte_sel;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.led_tx   = busy_q;
  assign bus.mem_addr = mem_addr_q;

  // tx is driven from a flop that is updated on each bit boundary, so the pin
  // changes exactly once per bit and never follows an input combinationally.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      wait_cnt   <= '0;
      bit_cnt    <= '0;
      mem_addr_q <= '0;
      end_addr_q <= '0;
      shifter    <= '0;
      word_lo    <= '0;
      byte_sel   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all next-state terms read the
      // values from before this edge, regardless of statement order.
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            end_addr_q <= bus.end_addr;
            mem_addr_q <= bus.start_addr;
            busy_q     <= 1'b1;
            wait_cnt   <= '0;
            state      <= S_WAIT;
          end
        end

        S_FETCH: state <= S_IDLE;

        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_LATCH;
          else                       wait_cnt <= wait_cnt + 2'd1;
        end

        S_LATCH: begin
          word_lo  <= bus.mem_data[7:0];
          shifter  <= bus.mem_data[15:8];
          byte_sel <= 1'b0;
          baud_cnt <= '0;
          tx_q     <= 1'b0;
          state    <= S_START_BIT;
        end

        S_START_BIT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= shifter[0];
            shifter  <= {1'b0, shifter[7:1]};
            state    <= S_DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_DATA_BITS: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= S_STOP_BIT;
            end else begin
              tx_q    <= shifter[0];
              shifter <= {1'b0, shifter[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_STOP_BIT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // Low byte follows the high byte with no idle cycle in between.
            if (!byte_sel) begin
              shifter  <= word_lo;
              byte_sel <= 1'b1;
              tx_q     <= 1'b0;
              state    <= S_START_BIT;
            end else begin
              state <= S_NEXT;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_NEXT: begin
          if (mem_addr_q == end_addr_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_FINISH;
          end else begin
            mem_addr_q <= mem_addr_q + 16'd1;
            wait_cnt   <= '0;
            state      <= S_WAIT;
          end
        end

        S_FINISH: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: random memory contents and ranges, checked cycle by cycle
// against a frame-level model and a UART byte decoder on tx.
module tb_uart_word_tx;
  localparam int B  = 4;
  localparam int L0 = 1;
  localparam int L1 = 3;

  typedef struct packed {
    logic        tx;
    logic        busy;
    logic        done;
    logic [15:0] addr;
  } cyc_t;

  logic clk_100 = 1'b0;
  logic rst;
  uart_word_tx_if bus0();
  uart_word_tx_if bus1();

  logic [15:0] mem [0:65535];
  cyc_t        exp_q[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  rx_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk_100 = ~clk_100;

  uart_word_tx #(.BAUD_DIV(B), .MEM_LATENCY(L0)) dut0 (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus0)
  );

  uart_word_tx #(.BAUD_DIV(B), .MEM_LATENCY(L1)) dut1 (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus1)
  );

  // Single-cycle-latency read port for dut0.
  always @(posedge clk_100) bus0.mem_data <= mem[bus0.mem_addr];

  // Independent UART receiver: samples each bit in its middle.
  initial begin : rx_decoder
    logic [7:0] b;
    forever begin
      @(negedge clk_100);
      if (bus0.tx === 1'b0) begin
        repeat (B / 2) @(negedge clk_100);
        for (int j = 0; j < 8; j++) begin
          repeat (B) @(negedge clk_100);
          b[j] = bus0.tx;
        end
        repeat (B) @(negedge clk_100);
        rx_q.push_back(b);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic [15:0] a);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    exp_bytes.push_back(b);
    for (int j = 0; j < 10; j++)
      repeat (B) exp_q.push_back({fr[j], 1'b1, 1'b0, a});
  endtask

  // Expected per-cycle tx/busy/done/mem_addr, starting the cycle after start is accepted.
  task automatic build_model(input logic [15:0] s, input logic [15:0] e);
    logic [15:0] span;
    logic [15:0] a;
    logic [15:0] w;
    int          n;
    exp_q.delete();
    exp_bytes.delete();
    span = e - s;
    n    = int'(span) + 1;
    a    = s;
    for (int k = 0; k < n; k++) begin
      a = s + 16'(k);
      w = mem[a];
      repeat (L0 + 1) exp_q.push_back({1'b1, 1'b1, 1'b0, a});
      push_byte(w[15:8], a);
      push_byte(w[7:0], a);
      exp_q.push_back({1'b1, 1'b1, 1'b0, a});
    end
    exp_q.push_back({1'b1, 1'b0, 1'b1, a});
    repeat (4) exp_q.push_back({1'b1, 1'b0, 1'b0, a});
  endtask

  task automatic run_transfer(input string name, input logic [15:0] s, input logic [15:0] e,
                              input bit repulse);
    int   bad;
    int   first_bad;
    int   dones;
    int   idx_repulse;
    cyc_t got;
    cyc_t gw;
    cyc_t ew;
    bad         = 0;
    first_bad   = -1;
    dones       = 0;
    idx_repulse = L0 + 1 + 10 * B + 5;
    gw          = '0;
    ew          = '0;
    build_model(s, e);
    rx_q.delete();
    bus0.start_addr = s;
    bus0.end_addr   = e;
    bus0.start      = 1'b1;
    @(posedge clk_100);
    #1;
    bus0.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk_100);
      got = {bus0.tx, bus0.busy, bus0.done, bus0.mem_addr};
      if (got !== exp_q[i] || bus0.led_tx !== exp_q[i].busy) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = i;
          gw        = got;
          ew        = exp_q[i];
        end
      end
      if (bus0.done === 1'b1) dones++;
      if (repulse && i == idx_repulse) begin
        bus0.start      = 1'b1;
        bus0.start_addr = 16'h0200;
        bus0.end_addr   = 16'h0205;
      end else begin
        bus0.start = 1'b0;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s wave: %0d bad cycles, first at %0d got tx/busy/done/addr=%h required %h",
               name, bad, first_bad, gw, ew);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d required 1", name, dones);
    end
    checks++;
    if (rx_q.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d required %0d", name, rx_q.size(), exp_bytes.size());
    end else begin
      for (int k = 0; k < exp_bytes.size(); k++) begin
        checks++;
        if (rx_q[k] !== exp_bytes[k]) begin
          errors++;
          $display("FAIL %s byte[%0d]: got %h required %h", name, k, rx_q[k], exp_bytes[k]);
        end
      end
    end
  endtask

  task automatic check_idle(input string name, input logic [15:0] addr);
    checks++;
    if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 ||
        bus0.led_tx !== 1'b0 || bus0.mem_addr !== addr) begin
      errors++;
      $display("FAIL %s: got tx=%b busy=%b done=%b led=%b addr=%h required 1 0 0 0 %h",
               name, bus0.tx, bus0.busy, bus0.done, bus0.led_tx, bus0.mem_addr, addr);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus0.start      = 1'b1;
    bus0.start_addr = 16'h1234;
    bus0.end_addr   = 16'h1234;
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    check_idle("reset_values", 16'h0000);
    checks++;
    if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values_dut1: got tx=%b busy=%b addr=%h required 1 0 0000",
               bus1.tx, bus1.busy, bus1.mem_addr);
    end
    rst        = 1'b0;
    bus0.start = 1'b0;
    @(negedge clk_100);
    check_idle("reset_beats_start", 16'h0000);
  endtask

  task automatic test_single();
    mem[16'h0010] = 16'hA55A;
    run_transfer("single", 16'h0010, 16'h0010, 1'b0);
  endtask

  task automatic test_range();
    mem[16'h0100] = 16'h1234;
    mem[16'h0101] = 16'hABCD;
    mem[16'h0102] = 16'h00FF;
    run_transfer("range", 16'h0100, 16'h0102, 1'b0);
  endtask

  task automatic test_wrap();
    run_transfer("wrap", 16'hFFFF, 16'h0001, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] s;
    for (int t = 0; t < 4; t++) begin
      s = 16'($urandom);
      run_transfer("random", s, s + 16'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    run_transfer("start_ignored", 16'h0300, 16'h0301, 1'b1);
  endtask

  task automatic test_reset_mid();
    int bad;
    bad             = 0;
    bus0.start_addr = 16'($urandom_range(1, 16'hFFFF));
    bus0.end_addr   = bus0.start_addr;
    bus0.start      = 1'b1;
    @(posedge clk_100);
    #1;
    bus0.start = 1'b0;
    // Index 19 lies inside data bit 3 of the high byte.
    for (int i = 0; i <= 19; i++) @(negedge clk_100);
    rst = 1'b1;
    @(posedge clk_100);
    #1;
    rst = 1'b0;
    @(negedge clk_100);
    check_idle("reset_mid_frame", 16'h0000);
    repeat (30 * B) begin
      @(negedge clk_100);
      if (bus0.tx !== 1'b1 || bus0.done !== 1'b0 || bus0.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_latency();
    logic [15:0] got;
    logic [15:0] want;
    int          rel;
    int          slot;
    int          done_idx;
    logic [15:0] addr_latch;
    got             = '0;
    want            = 16'($urandom) ^ 16'h8001;
    done_idx        = -1;
    addr_latch      = '0;
    bus1.start_addr = 16'h0042;
    bus1.end_addr   = 16'h0042;
    bus1.mem_data   = ~want;
    bus1.start      = 1'b1;
    @(posedge clk_100);
    #1;
    bus1.start = 1'b0;
    for (int i = 0; i < L1 + 1 + 20 * B + 6; i++) begin
      @(negedge clk_100);
      if (i == 2) bus1.mem_data = want ^ 16'h0F0F;
      if (i == 3) begin
        bus1.mem_data = want;
        addr_latch    = bus1.mem_addr;
      end
      if (i == 4) bus1.mem_data = want ^ 16'hF0F0;
      rel = i - (L1 + 1);
      if (rel >= 0 && rel < 20 * B && rel % B == B / 2) begin
        slot = rel / B;
        if (slot % 10 >= 1 && slot % 10 <= 8)
          got[(slot < 10 ? 8 : 0) + slot % 10 - 1] = bus1.tx;
      end
      if (bus1.done === 1'b1 && done_idx < 0) done_idx = i;
    end
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL latency_word: got %h required %h", got, want);
    end
    checks++;
    if (done_idx != L1 + 1 + 20 * B + 1) begin
      errors++;
      $display("FAIL latency_done_cycle: got %0d required %0d", done_idx, L1 + 1 + 20 * B + 1);
    end
    checks++;
    if (addr_latch !== 16'h0042) begin
      errors++;
      $display("FAIL latency_addr: got %h required 0042", addr_latch);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    rst             = 1'b1;
    bus0.start      = 1'b0;
    bus0.start_addr = '0;
    bus0.end_addr   = '0;
    bus1.start      = 1'b0;
    bus1.start_addr = '0;
    bus1.end_addr   = '0;
    bus1.mem_data   = '0;
    test_reset();
    test_single();
    test_range();
    test_wrap();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Transmit-side counterpart to the word loader's receive path. It streams a contiguous range of 16-bit words from memory out of the UART TxD pin.
- Each word is sent as two 8N1 bytes, high byte first, which matches the receive side's byte-to-word assembly order.
- Contains its own bit-level serializer and baud counter; it does not instantiate async_transmitter.
- Sits between the image/data memory read port and the board tx pin. It is started by the processor control (ctrl_io_send-style) strobe.

Parameters:
- BAUD_DIV, 868, clocks per UART bit (100 MHz / 115200, rounded). Legal range 2..65535.
- MEM_LATENCY, 1, clocks from mem_addr change to valid mem_data. Legal range 1..4.

Ports:
- clk_100  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  16  first word address; latched on accepted start.
- end_addr  in  16  last word address (inclusive); latched on accepted start.
- mem_data  in  16  memory read data.
- mem_addr  out  16  memory read address.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse after the last stop bit completes.
- led_tx  out  1  equals busy.

Behaviour:
- Reset values: tx=1, busy=0, done=0, mem_addr=0, led_tx=0. FSM goes to IDLE, all counters go to 0.
- rst has priority over every other input in the same cycle. A reset mid-frame aborts the frame; tx is 1 on the next cycle. No partial-byte completion, no done pulse.
- FSM states: IDLE, FETCH, WAIT, LATCH, START_BIT, DATA_BITS, STOP_BIT, NEXT, FINISH.
- IDLE:
  - tx=1.
  - On start=1: latch end_addr, set mem_addr=start_addr, go to WAIT.
- WAIT: hold mem_addr for MEM_LATENCY cycles, then go to LATCH.
- LATCH: capture mem_data into a 16-bit word register. Load the byte shifter with word[15:8], clear byte_sel, go to START_BIT.
- START_BIT: tx=0 for BAUD_DIV cycles.
- DATA_BITS: 8 bits, LSB first, each held BAUD_DIV cycles.
- STOP_BIT: tx=1 for BAUD_DIV cycles.
  - If byte_sel=0: load word[7:0], set byte_sel=1, go to START_BIT. There are zero idle cycles between the high and low bytes.
  - If byte_sel=1: go to NEXT.
- NEXT (1 cycle):
  - If mem_addr==end_addr: go to FINISH.
  - Otherwise mem_addr<=mem_addr+1 (mod 2^16), go to WAIT.
  - The gap between words is therefore 1+MEM_LATENCY+1 idle-high cycles after the stop bit.
- FINISH (1 cycle): done=1, busy=0, go to IDLE.
- FETCH is reserved and unused. An implementation may merge it into IDLE.
- Frame length is exactly 10*BAUD_DIV cycles per byte. The baud counter reloads at every bit boundary and has no drift.
- Address arithmetic is 16-bit and wraps. If end_addr < start_addr, the range wraps through 0xFFFF to 0x0000. If start_addr==end_addr, exactly one word is sent.
- start while busy=1 is ignored. Latched start_addr/end_addr are not affected by input changes during a transfer.
- mem_data is sampled only in LATCH. Changes to it at other times have no effect.
- tx is registered and has no combinational path from any input.

Test Plan:
- Single word, BAUD_DIV=4, MEM_LATENCY=1, mem[0x0010]=0xA55A, start_addr=end_addr=0x0010:
  - tx shows start, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), stop, then immediately start, 0,1,0,1,1,0,1,0 (0x5A), stop. Each bit lasts 4 clocks.
  - done pulses exactly once, 80 cycles plus fixed overhead after start. busy and led_tx are high throughout.
- Range 0x0100..0x0102 holding 0x1234, 0xABCD, 0x00FF:
  - Decoded byte stream is 12 34 AB CD 00 FF.
  - mem_addr steps 0x0100, 0x0101, 0x0102.
  - Inter-word idle gap is 3 cycles; intra-word gap is 0.
- Wrap range start_addr=0xFFFF, end_addr=0x0001 -> three words are sent from addresses 0xFFFF, 0x0000, 0x0001, then done.
- start re-pulsed during the second byte, with start_addr changed to 0x0200 -> ignored. The current transfer completes unchanged, and a single done is produced.
- rst asserted for 1 cycle during bit 3 of a byte:
  - The next cycle shows tx=1, busy=0, done=0, mem_addr=0.
  - No further edges appear on tx until a new start.
- MEM_LATENCY=3 with mem_data changed 2 cycles after the address -> the word latched is the value present at cycle 3, i.e. in LATCH.
